// File: rtl/lvds_align_pkg.sv
// Shared types and constants for the LVDS receive word aligner.
package lvds_align_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SLIP,
        WAIT,
        LOCKED,
        FAIL
    } lane_state_e;

    localparam int SLIP_PULSE = 2;

    // Ceiling log2, never below 1 so that counters always have at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/lvds_align_lane.sv
// One lane's training FSM: compare against the training word, bit-slip until locked, flag failure.
module lvds_align_lane
    import lvds_align_pkg::*;
#(
    parameter int               DESER         = 8,
    parameter logic [DESER-1:0] TRAIN_PATTERN = 8'hA5,
    parameter int               LOCK_COUNT    = 16,
    parameter int               SLIP_WAIT     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             train_en,
    input  logic [DESER-1:0] rx_word,
    output logic             rx_data_align,
    output logic             ch_aligned,
    output logic             align_err
);

    localparam int MW   = clog2(LOCK_COUNT + 1);
    localparam int SW   = clog2(DESER + 1);
    localparam int TMAX = (SLIP_PULSE > SLIP_WAIT) ? SLIP_PULSE : SLIP_WAIT;
    localparam int TW   = clog2(TMAX + 1);

    lane_state_e   state_q, state_d;
    logic [MW-1:0] match_cnt_q, match_cnt_d;
    logic [SW-1:0] slip_cnt_q, slip_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          align_q, align_d;
    logic          aligned_q, aligned_d;
    logic          err_q, err_d;
    logic          match;

    assign match = (rx_word == TRAIN_PATTERN);

    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        slip_cnt_d  = slip_cnt_q;
        timer_d     = timer_q;
        align_d     = align_q;
        aligned_d   = aligned_q;
        err_d       = err_q;
        if (!pll_locked) begin
            // Losing the receiver clock invalidates everything, including a slip in flight.
            state_d   = IDLE;
            timer_d   = '0;
            align_d   = 1'b0;
            aligned_d = 1'b0;
            err_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (train_en) begin
                        state_d     = CHECK;
                        match_cnt_d = '0;
                        slip_cnt_d  = '0;
                    end
                end
                CHECK: begin
                    if (!train_en) begin
                        state_d = IDLE;
                    end else if (match) begin
                        match_cnt_d = match_cnt_q + 1'b1;
                        if (match_cnt_q == MW'(LOCK_COUNT - 1)) begin
                            state_d   = LOCKED;
                            aligned_d = 1'b1;
                        end
                    end else begin
                        match_cnt_d = '0;
                        if (slip_cnt_q == SW'(DESER)) begin
                            state_d = FAIL;
                            err_d   = 1'b1;
                        end else begin
                            state_d    = SLIP;
                            align_d    = 1'b1;
                            slip_cnt_d = slip_cnt_q + 1'b1;
                            timer_d    = '0;
                        end
                    end
                end
                SLIP: begin
                    if (!train_en) begin
                        state_d = IDLE;
                        align_d = 1'b0;
                    end else if (timer_q == TW'(SLIP_PULSE - 1)) begin
                        state_d = WAIT;
                        align_d = 1'b0;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                WAIT: begin
                    if (!train_en) begin
                        state_d = IDLE;
                    end else if (timer_q == TW'(SLIP_WAIT - 1)) begin
                        state_d = CHECK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (train_en && !match) begin
                        state_d     = CHECK;
                        aligned_d   = 1'b0;
                        match_cnt_d = '0;
                        slip_cnt_d  = '0;
                    end
                end
                FAIL: begin
                    if (!train_en) begin
                        state_d = IDLE;
                        err_d   = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            match_cnt_q <= '0;
            slip_cnt_q  <= '0;
            timer_q     <= '0;
            align_q     <= 1'b0;
            aligned_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            slip_cnt_q  <= slip_cnt_d;
            timer_q     <= timer_d;
            align_q     <= align_d;
            aligned_q   <= aligned_d;
            err_q       <= err_d;
        end
    end

    assign rx_data_align = align_q;
    assign ch_aligned    = aligned_q;
    assign align_err     = err_q;

endmodule

// File: rtl/lvds_rx_word_aligner.sv
// Multi-lane LVDS word aligner: one training FSM per lane plus registered payload and status.
module lvds_rx_word_aligner #(
    parameter int               CHANNELS      = 1,
    parameter int               DESER         = 8,
    parameter logic [DESER-1:0] TRAIN_PATTERN = 8'hA5,
    parameter int               LOCK_COUNT    = 16,
    parameter int               SLIP_WAIT     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pll_locked,
    input  logic                      train_en,
    input  logic [CHANNELS*DESER-1:0] rx_data,
    output logic [CHANNELS-1:0]       rx_data_align,
    output logic [CHANNELS-1:0]       ch_aligned,
    output logic                      all_aligned,
    output logic [CHANNELS-1:0]       align_err,
    output logic [CHANNELS*DESER-1:0] data_out,
    output logic                      data_valid
);

    logic                      all_aligned_q, all_aligned_d;
    logic [CHANNELS*DESER-1:0] data_out_q, data_out_d;
    logic                      data_valid_q, data_valid_d;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        lvds_align_lane #(
            .DESER        (DESER),
            .TRAIN_PATTERN(TRAIN_PATTERN),
            .LOCK_COUNT   (LOCK_COUNT),
            .SLIP_WAIT    (SLIP_WAIT)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .pll_locked   (pll_locked),
            .train_en     (train_en),
            .rx_word      (rx_data[g*DESER +: DESER]),
            .rx_data_align(rx_data_align[g]),
            .ch_aligned   (ch_aligned[g]),
            .align_err    (align_err[g])
        );
    end

    // data_valid uses the registered all_aligned so it lines up with the data_out register.
    always_comb begin
        all_aligned_d = &ch_aligned;
        data_out_d    = rx_data;
        data_valid_d  = all_aligned_q && !train_en && pll_locked;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            all_aligned_q <= 1'b0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
        end else begin
            all_aligned_q <= all_aligned_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
        end
    end

    assign all_aligned = all_aligned_q;
    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;

endmodule

// File: tb/tb_lvds_rx_word_aligner.sv
// Directed bench: two lanes driven by a bit-slip receiver model with hand-computed timing.
module tb_lvds_rx_word_aligner;

    logic        clk;
    logic        rst;
    logic        pll_locked;
    logic        train_en;
    logic [15:0] rx_data;
    logic [1:0]  rx_data_align;
    logic [1:0]  ch_aligned;
    logic        all_aligned;
    logic [1:0]  align_err;
    logic [15:0] data_out;
    logic        data_valid;

    int checks = 0;
    int errors = 0;

    // Receiver model state
    logic [2:0] rot [2];
    int         pulses [2];
    int         hi_run [2];
    bit         pend [2];
    bit         align_prev [2];
    bit         force_en [2];
    logic [7:0] force_val [2];
    bit         bad_width;

    lvds_rx_word_aligner #(
        .CHANNELS     (2),
        .DESER        (8),
        .TRAIN_PATTERN(8'hA5),
        .LOCK_COUNT   (16),
        .SLIP_WAIT    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .train_en     (train_en),
        .rx_data      (rx_data),
        .rx_data_align(rx_data_align),
        .ch_aligned   (ch_aligned),
        .all_aligned  (all_aligned),
        .align_err    (align_err),
        .data_out     (data_out),
        .data_valid   (data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rotl(input logic [7:0] w, input int k);
        logic [15:0] d;
        d = {w, w} >> (8 - (k % 8));
        return d[7:0];
    endfunction

    task automatic drive();
        for (int n = 0; n < 2; n++)
            rx_data[n*8 +: 8] = force_en[n] ? force_val[n] : rotl(8'hA5, int'(rot[n]));
    endtask

    // One clock: sample outputs after the edge, advance the slip model, redrive words.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int n = 0; n < 2; n++) begin
            if (pend[n]) begin
                rot[n] = rot[n] + 3'd1;
                pend[n] = 1'b0;
            end
            if (rx_data_align[n]) begin
                if (!align_prev[n]) pulses[n]++;
                hi_run[n]++;
            end else if (align_prev[n]) begin
                pend[n] = 1'b1;
                if (hi_run[n] != 2) bad_width = 1'b1;
                hi_run[n] = 0;
            end
            align_prev[n] = rx_data_align[n];
        end
        drive();
    endtask

    task automatic test_reset();
        rst = 1'b1; pll_locked = 1'b1; train_en = 1'b1;
        for (int n = 0; n < 2; n++) begin
            rot[n] = 3'd0; pulses[n] = 0; hi_run[n] = 0; pend[n] = 1'b0;
            align_prev[n] = 1'b0; force_en[n] = 1'b0; force_val[n] = 8'h00;
        end
        drive();
        repeat (3) tick();
        checks++; if (rx_data_align !== 2'b00) begin errors++; $display("FAIL reset_align got %b want 00", rx_data_align); end
        checks++; if (ch_aligned !== 2'b00) begin errors++; $display("FAIL reset_ch_aligned got %b want 00", ch_aligned); end
        checks++; if (all_aligned !== 1'b0) begin errors++; $display("FAIL reset_all_aligned got %b want 0", all_aligned); end
        checks++; if (align_err !== 2'b00) begin errors++; $display("FAIL reset_align_err got %b want 00", align_err); end
        checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL reset_data_out got %h want 0000", data_out); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid got %b want 0", data_valid); end
    endtask

    task automatic test_align();
        int cyc;
        rot[0] = 3'd0; rot[1] = 3'd3; pulses[0] = 0; pulses[1] = 0; bad_width = 1'b0;
        drive();
        rst = 1'b0;
        cyc = 0;
        while (ch_aligned[0] !== 1'b1 && cyc < 40) begin tick(); cyc++; end
        checks++; if (cyc != 17) begin errors++; $display("FAIL lane0_lock_time got %0d want 17", cyc); end
        checks++; if (pulses[0] != 0) begin errors++; $display("FAIL lane0_slips got %0d want 0", pulses[0]); end
        while (ch_aligned[1] !== 1'b1 && cyc < 200) begin tick(); cyc++; end
        checks++; if (cyc != 52) begin errors++; $display("FAIL lane1_lock_time got %0d want 52", cyc); end
        checks++; if (pulses[1] != 5) begin errors++; $display("FAIL lane1_slips got %0d want 5", pulses[1]); end
        checks++; if (bad_width !== 1'b0) begin errors++; $display("FAIL slip_pulse_width got bad=%0b want 0", bad_width); end
        checks++; if (all_aligned !== 1'b0) begin errors++; $display("FAIL all_aligned_lag got %b want 0", all_aligned); end
        tick();
        checks++; if (all_aligned !== 1'b1) begin errors++; $display("FAIL all_aligned_rise got %b want 1", all_aligned); end
    endtask

    task automatic test_payload();
        train_en = 1'b0;
        force_en[0] = 1'b1; force_val[0] = 8'h3C;
        force_en[1] = 1'b1; force_val[1] = 8'hC3;
        drive();
        tick();
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL payload_valid got %b want 1", data_valid); end
        checks++; if (data_out !== 16'hC33C) begin errors++; $display("FAIL payload_word0 got %h want c33c", data_out); end
        force_val[0] = 8'hC3; force_val[1] = 8'h3C;
        drive();
        #2;
        checks++; if (data_out !== 16'hC33C) begin errors++; $display("FAIL payload_delay got %h want c33c", data_out); end
        tick();
        checks++; if (data_out !== 16'h3CC3) begin errors++; $display("FAIL payload_word1 got %h want 3cc3", data_out); end
        checks++; if (ch_aligned !== 2'b11) begin errors++; $display("FAIL payload_locked got %b want 11", ch_aligned); end
    endtask

    task automatic test_relock();
        int p0;
        bit lane1_ok;
        force_en[0] = 1'b0; force_en[1] = 1'b0; train_en = 1'b1;
        drive();
        tick(); tick();
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL train_valid got %b want 0", data_valid); end
        checks++; if (ch_aligned !== 2'b11) begin errors++; $display("FAIL retrain_hold got %b want 11", ch_aligned); end
        p0 = pulses[0]; lane1_ok = 1'b1;
        force_en[0] = 1'b1; force_val[0] = 8'hFF;
        drive();
        tick();
        checks++; if (ch_aligned !== 2'b10) begin errors++; $display("FAIL glitch_drop got %b want 10", ch_aligned); end
        force_en[0] = 1'b0;
        drive();
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (ch_aligned[1] !== 1'b1) lane1_ok = 1'b0;
            if (i == 15) begin
                checks++; if (ch_aligned[0] !== 1'b0) begin errors++; $display("FAIL relock_early got %b want 0", ch_aligned[0]); end
            end
        end
        checks++; if (ch_aligned[0] !== 1'b1) begin errors++; $display("FAIL relock got %b want 1", ch_aligned[0]); end
        checks++; if (pulses[0] != p0) begin errors++; $display("FAIL relock_slips got %0d want %0d", pulses[0], p0); end
        checks++; if (lane1_ok !== 1'b1) begin errors++; $display("FAIL lane1_undisturbed got %0b want 1", lane1_ok); end
        tick();
        checks++; if (all_aligned !== 1'b1) begin errors++; $display("FAIL relock_all got %b want 1", all_aligned); end
    endtask

    task automatic test_pll_drop();
        int  cyc;
        bit  stray;
        rot[0] = 3'd5;
        drive();
        cyc = 0;
        while (rx_data_align[0] !== 1'b1 && cyc < 20) begin tick(); cyc++; end
        checks++; if (rx_data_align[0] !== 1'b1) begin errors++; $display("FAIL pll_slip_start got %b want 1", rx_data_align[0]); end
        pll_locked = 1'b0;
        tick();
        checks++; if (rx_data_align !== 2'b00) begin errors++; $display("FAIL pll_truncate got %b want 00", rx_data_align); end
        checks++; if (ch_aligned !== 2'b00) begin errors++; $display("FAIL pll_ch_aligned got %b want 00", ch_aligned); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL pll_valid got %b want 0", data_valid); end
        stray = 1'b0;
        repeat (5) begin tick(); if (rx_data_align !== 2'b00) stray = 1'b1; end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL pll_low_slip got %0b want 0", stray); end
        pll_locked = 1'b1;
        cyc = 0;
        while (ch_aligned !== 2'b11 && cyc < 300) begin tick(); cyc++; end
        checks++; if (ch_aligned !== 2'b11) begin errors++; $display("FAIL pll_retrain got %b want 11", ch_aligned); end
        tick();
        checks++; if (all_aligned !== 1'b1) begin errors++; $display("FAIL pll_retrain_all got %b want 1", all_aligned); end
    endtask

    task automatic test_fail();
        int cyc;
        bit extra;
        pulses[1] = 0;
        force_en[1] = 1'b1; force_val[1] = 8'h00;
        drive();
        cyc = 0;
        while (align_err[1] !== 1'b1 && cyc < 100) begin tick(); cyc++; end
        checks++; if (cyc != 58) begin errors++; $display("FAIL fail_time got %0d want 58", cyc); end
        checks++; if (pulses[1] != 8) begin errors++; $display("FAIL fail_slips got %0d want 8", pulses[1]); end
        extra = 1'b0;
        repeat (30) begin tick(); if (rx_data_align[1] !== 1'b0) extra = 1'b1; end
        checks++; if (extra !== 1'b0 || pulses[1] != 8) begin errors++; $display("FAIL fail_no_ninth got pulses=%0d want 8", pulses[1]); end
        checks++; if (align_err !== 2'b10) begin errors++; $display("FAIL fail_hold got %b want 10", align_err); end
        checks++; if (ch_aligned[0] !== 1'b1) begin errors++; $display("FAIL fail_lane0 got %b want 1", ch_aligned[0]); end
        train_en = 1'b0;
        drive();
        tick();
        checks++; if (align_err !== 2'b00) begin errors++; $display("FAIL fail_clear got %b want 00", align_err); end
        checks++; if (ch_aligned[0] !== 1'b1) begin errors++; $display("FAIL fail_lane0_idle got %b want 1", ch_aligned[0]); end
    endtask

    task automatic test_rst_mid_wait();
        int cyc;
        bit slipped;
        train_en = 1'b1;
        drive();
        cyc = 0;
        while (rx_data_align[1] !== 1'b1 && cyc < 20) begin tick(); cyc++; end
        while (rx_data_align[1] !== 1'b0 && cyc < 20) begin tick(); cyc++; end
        checks++; if (cyc >= 20) begin errors++; $display("FAIL wait_entry got timeout at %0d want <20", cyc); end
        tick();
        rst = 1'b1;
        tick();
        checks++; if (rx_data_align !== 2'b00) begin errors++; $display("FAIL rst_align got %b want 00", rx_data_align); end
        checks++; if (ch_aligned !== 2'b00) begin errors++; $display("FAIL rst_ch_aligned got %b want 00", ch_aligned); end
        checks++; if (all_aligned !== 1'b0) begin errors++; $display("FAIL rst_all got %b want 0", all_aligned); end
        checks++; if (align_err !== 2'b00) begin errors++; $display("FAIL rst_err got %b want 00", align_err); end
        checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL rst_data got %h want 0000", data_out); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", data_valid); end
        slipped = 1'b0;
        repeat (10) begin tick(); if (rx_data_align !== 2'b00) slipped = 1'b1; end
        checks++; if (slipped !== 1'b0) begin errors++; $display("FAIL rst_no_slip got %0b want 0", slipped); end
        rst = 1'b0;
        cyc = 0;
        while (ch_aligned[0] !== 1'b1 && cyc < 40) begin tick(); cyc++; end
        checks++; if (cyc != 17) begin errors++; $display("FAIL rst_from_idle got %0d want 17", cyc); end
    endtask

    initial begin
        rx_data = '0;
        test_reset();
        test_align();
        test_payload();
        test_relock();
        test_pll_drop();
        test_fail();
        test_rst_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
